// File: rtl/pipelined_barrel_shifter.sv
// Pipelined W-bit barrel shifter (rotate / logical / arithmetic, left or right) with
// valid/ready handshakes. Optional zero flag output when BSH_ZERO_FLAG_EN is defined.
module pipelined_barrel_shifter #(
  parameter int unsigned W    = 8,
  parameter int unsigned PIPE = 1,
  localparam int unsigned SH_W = $clog2(W) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [SH_W-1:0] in_shamt,
  input  logic            in_left,
  input  logic [1:0]      in_kind,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef BSH_ZERO_FLAG_EN
  output logic            out_zero,
`endif
  output logic [W-1:0]    out_data
);

  localparam int unsigned LG = $clog2(W);
  localparam logic [1:0] KindRot   = 2'b00;
  localparam logic [1:0] KindArith = 2'b10;

  logic advance;

  // Index k holds the values entering shift level k; index LG feeds the output register.
  logic [LG:0][W-1:0]      c_data;
  logic [LG:0]             c_valid;
  logic [LG-1:0][SH_W-1:0] c_shamt;
  logic [LG-1:0]           c_left;
  logic [LG-1:0][1:0]      c_kind;
  logic [LG-1:0]           c_sign;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !reset;

  assign c_data[0]  = in_data;
  assign c_valid[0] = in_valid && in_ready;
  assign c_shamt[0] = in_shamt;
  assign c_left[0]  = in_left;
  assign c_kind[0]  = in_kind;
  assign c_sign[0]  = in_data[W-1];

  function automatic logic [W-1:0] shift_step(input logic [W-1:0] d, input int unsigned amt,
                                               input logic left, input logic [1:0] kind,
                                               input logic sign);
    logic [W-1:0] fill;
    fill = (!left && kind == KindArith && sign) ? ~({W{1'b1}} >> amt) : '0;
    if (kind == KindRot) begin
      shift_step = left ? ((d << amt) | (d >> (W - amt))) : ((d >> amt) | (d << (W - amt)));
    end else begin
      shift_step = left ? (d << amt) : ((d >> amt) | fill);
    end
  endfunction

  for (genvar k = 0; k < LG; k++) begin : g_lvl
    logic [W-1:0] result;

    always_comb begin
      result = c_shamt[k][k] ?
               shift_step(c_data[k], (1 << k), c_left[k], c_kind[k], c_sign[k]) : c_data[k];
      // Out-of-range shifts collapse to the fill pattern; rotates ignore the top bit.
      if (k == LG - 1 && c_kind[k] != KindRot && c_shamt[k][SH_W-1]) begin
        result = (!c_left[k] && c_kind[k] == KindArith && c_sign[k]) ? '1 : '0;
      end
    end

    if (k == LG - 1) begin : g_last
      assign c_data[k+1]  = result;
      assign c_valid[k+1] = c_valid[k];
    end else if (PIPE != 0) begin : g_reg
      logic [W-1:0]    data_q;
      logic            valid_q;
      logic [SH_W-1:0] shamt_q;
      logic            left_q;
      logic [1:0]      kind_q;
      logic            sign_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
        end else if (advance) begin
          valid_q <= c_valid[k];
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          data_q  <= result;
          shamt_q <= c_shamt[k];
          left_q  <= c_left[k];
          kind_q  <= c_kind[k];
          sign_q  <= c_sign[k];
        end
      end

      assign c_data[k+1]  = data_q;
      assign c_valid[k+1] = valid_q;
      assign c_shamt[k+1] = shamt_q;
      assign c_left[k+1]  = left_q;
      assign c_kind[k+1]  = kind_q;
      assign c_sign[k+1]  = sign_q;
    end else begin : g_comb
      assign c_data[k+1]  = result;
      assign c_valid[k+1] = c_valid[k];
      assign c_shamt[k+1] = c_shamt[k];
      assign c_left[k+1]  = c_left[k];
      assign c_kind[k+1]  = c_kind[k];
      assign c_sign[k+1]  = c_sign[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= c_valid[LG];
      out_data  <= c_data[LG];
    end
  end

`ifdef BSH_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_zero <= 1'b0;
    end else if (advance) begin
      out_zero <= (c_data[LG] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised + directed bench for pipelined_barrel_shifter; drives a PIPE=1 and a PIPE=0
// instance from the same stimulus and checks each against a behavioural scoreboard.
module tb_pipelined_barrel_shifter;

  localparam int unsigned W    = 8;
  localparam int unsigned LG   = $clog2(W);
  localparam int unsigned SH_W = LG + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic [SH_W-1:0] in_shamt;
  logic            in_left;
  logic [1:0]      in_kind;
  logic            out_ready;

  logic [1:0]      ir;
  logic [1:0]      ov;
  logic [W-1:0]    od [2];
`ifdef BSH_ZERO_FLAG_EN
  logic [1:0]      oz;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] exp_mem [2][256];
  int           wr [2];
  int           rd [2];
  logic         hold [2];
  logic [W-1:0] held [2];

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.W(W), .PIPE(1)) u_dut_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (ir[1]),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_left  (in_left),
    .in_kind  (in_kind),
    .out_valid(ov[1]),
    .out_ready(out_ready),
`ifdef BSH_ZERO_FLAG_EN
    .out_zero (oz[1]),
`endif
    .out_data (od[1])
  );

  pipelined_barrel_shifter #(.W(W), .PIPE(0)) u_dut_flat (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (ir[0]),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_left  (in_left),
    .in_kind  (in_kind),
    .out_valid(ov[0]),
    .out_ready(out_ready),
`ifdef BSH_ZERO_FLAG_EN
    .out_zero (oz[0]),
`endif
    .out_data (od[0])
  );

  // Reference: the result of one beat straight from the operation's definition.
  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] d, input int n, input logic left,
                                          input logic [1:0] kind);
    logic [2*W-1:0] tmp;
    int r;
    if (kind == 2'b00) begin
      r = n % W;
      if (left) begin
        tmp = {d, d} << r;
        return tmp[2*W-1:W];
      end
      tmp = {d, d} >> r;
      return tmp[W-1:0];
    end
    if (n >= W) return (kind == 2'b10 && !left && d[W-1]) ? '1 : '0;
    if (left) return d << n;
    if (kind == 2'b10) return W'($signed(d) >>> n);
    return d >> n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pops are checked before same-cycle accepts are pushed.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        check($sformatf("in_ready_during_reset_dut%0d", d), ir[d], 0);
        wr[d] = 0;
        rd[d] = 0;
        hold[d] = 1'b0;
      end else begin
        check($sformatf("in_ready_rule_dut%0d", d), ir[d], !ov[d] || out_ready);
        if (hold[d]) begin
          check($sformatf("stall_valid_dut%0d", d), ov[d], 1);
          check($sformatf("stall_data_dut%0d", d), od[d], held[d]);
        end
        if (ov[d] && out_ready) begin
          if (rd[d] == wr[d]) begin
            nvec++;
            nerr++;
            $display("FAIL spurious_output_dut%0d: got valid with data %0h, required no output",
                     d, od[d]);
          end else begin
            check($sformatf("data_dut%0d", d), od[d], exp_mem[d][rd[d] % 256]);
`ifdef BSH_ZERO_FLAG_EN
            check($sformatf("zero_dut%0d", d), oz[d], exp_mem[d][rd[d] % 256] == '0);
`endif
            rd[d]++;
          end
        end
        hold[d] = ov[d] && !out_ready;
        held[d] = od[d];
        if (in_valid && ir[d]) begin
          exp_mem[d][wr[d] % 256] = ref_fn(in_data, int'(in_shamt), in_left, in_kind);
          wr[d]++;
        end
      end
    end
  end

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  // One beat into an idle pipeline; both instances must produce exp at their own latency.
  task automatic run(input string name, input logic [W-1:0] d, input int n, input logic left,
                     input logic [1:0] kind, input logic [W-1:0] exp);
    int lat [2];
    logic [W-1:0] got [2];
    go_idle();
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SH_W'(n);
    in_left  = left;
    in_kind  = kind;
    lat[0] = 0;
    lat[1] = 0;
    got[0] = '0;
    got[1] = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ov[i] && lat[i] == 0) begin
          lat[i] = c;
          got[i] = od[i];
        end
      end
    end
    check({name, "_latency_pipe"}, lat[1], LG);
    check({name, "_latency_flat"}, lat[0], 1);
    check({name, "_data_pipe"}, got[1], exp);
    check({name, "_data_flat"}, got[0], exp);
  endtask

  task automatic rand_beat();
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_shamt = ($urandom % 4 == 0) ? SH_W'(W) : SH_W'($urandom_range(0, 2**SH_W - 1));
    in_left  = 1'($urandom);
    in_kind  = 2'($urandom);
  endtask

  initial begin
    int first;
    int last;
    int cnt;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_left   = 1'b0;
    in_kind   = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_out_valid_dut%0d", i), ov[i], 0);
      check($sformatf("reset_out_data_dut%0d", i), od[i], 0);
      check($sformatf("reset_in_ready_dut%0d", i), ir[i], 0);
    end

    // Hand-computed literals pinning both the DUTs and the model.
    check("model_rol", ref_fn(8'hB4, 3, 1'b1, 2'b00), 8'hA5);
    check("model_asr8", ref_fn(8'h90, 8, 1'b0, 2'b10), 8'hFF);
    run("rol_b4_3", 8'hB4, 3, 1'b1, 2'b00, 8'hA5);
    run("asr_90_2", 8'h90, 2, 1'b0, 2'b10, 8'hE4);
    run("asr_90_8", 8'h90, 8, 1'b0, 2'b10, 8'hFF);
    run("lsr_90_8", 8'h90, 8, 1'b0, 2'b01, 8'h00);
    run("ror_90_8", 8'h90, 8, 1'b0, 2'b00, 8'h90);
    run("lsl_01_7", 8'h01, 7, 1'b1, 2'b01, 8'h80);
    run("lsl_01_8", 8'h01, 8, 1'b1, 2'b01, 8'h00);
    run("asl_81_1", 8'h81, 1, 1'b1, 2'b10, 8'h02);
    run("k11_rsh_90_2", 8'h90, 2, 1'b0, 2'b11, 8'h24);
    run("ror_b4_0", 8'hB4, 0, 1'b0, 2'b00, 8'hB4);

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    go_idle();
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c < 8) rand_beat();
      else in_valid = 1'b0;
      @(negedge clk);
      if (ov[1]) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      @(posedge clk);
    end
    check("stream_count", cnt, 8);
    check("stream_span", last - first, 7);

    // Five-cycle consumer stall mid-stream.
    go_idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      rand_beat();
      @(posedge clk);
    end
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_beat();
      @(negedge clk);
      check("stall_in_ready_pipe", ir[1], 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rand_beat();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Reset with three beats in flight.
    go_idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      rand_beat();
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid_pipe", ov[1], 0);
    check("post_reset_valid_flat", ov[0], 0);

    // Random traffic with random back-pressure and occasional resets.
    go_idle();
    for (int c = 0; c < 4000; c++) begin
      #1;
      if ($urandom % 4 != 0) rand_beat();
      else in_valid = 1'b0;
      out_ready = ($urandom % 4 != 0);
      reset     = ($urandom % 300 == 0);
      @(posedge clk);
    end

    go_idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_pipe", wr[1] - rd[1], 0);
    check("drain_flat", wr[0] - rd[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
